pcs_rx_decoder: RTL and testbench



---
 rtl/pcs_rx_decoder_pkg.sv | 72 +++++++
 rtl/pcs_rx_block_decode.sv | 118 +++++++++++
 rtl/pcs_rx_decoder.sv | 136 +++++++++++++
 tb/tb_pcs_rx_decoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_rx_decoder_pkg.sv
// ---------------------------------------------------------------------------
// pcs_rx_decoder_pkg
//
// Shared definitions for the receive-side 64b/66b block decoder:
//   - sync header values
//   - block type field values
//   - 7-bit control codes carried inside control blocks
//   - XGMII control characters and canned 64-bit lane patterns
//   - receive state machine and block class enumerations
//   - helpers that check and translate a single 7-bit control code
// ---------------------------------------------------------------------------
package pcs_rx_decoder_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam logic [7:0] BT_C  = 8'h1E;
  localparam logic [7:0] BT_S0 = 8'h78;
  localparam logic [7:0] BT_S4 = 8'h33;
  localparam logic [7:0] BT_T0 = 8'h87;
  localparam logic [7:0] BT_T1 = 8'h99;
  localparam logic [7:0] BT_T2 = 8'hAA;
  localparam logic [7:0] BT_T3 = 8'hB4;
  localparam logic [7:0] BT_T4 = 8'hCC;
  localparam logic [7:0] BT_T5 = 8'hD2;
  localparam logic [7:0] BT_T6 = 8'hE1;
  localparam logic [7:0] BT_T7 = 8'hFF;

  localparam logic [6:0] CC_IDLE = 7'h00;
  localparam logic [6:0] CC_ERR  = 7'h1E;

  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;

  localparam logic [63:0] XG_IDLE_BLOCK = {8{XG_IDLE}};
  localparam logic [63:0] XG_ERR_BLOCK  = {8{XG_ERROR}};
  localparam logic [7:0]  XC_ALL_CTRL   = 8'hFF;

  // Local-fault ordered set in both halves, reported while block lock is lost.
  localparam logic [63:0] XG_LBLOCK = {8'h01, 8'h00, 8'h00, XG_SEQ,
                                       8'h01, 8'h00, 8'h00, XG_SEQ};
  localparam logic [7:0]  XC_LBLOCK = 8'h11;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_C,
    ST_D,
    ST_E
  } rx_state_e;

  typedef enum logic [2:0] {
    BLK_C,
    BLK_S,
    BLK_T,
    BLK_D,
    BLK_E
  } blk_class_e;

  // Only idle and error codes are legal inside control and terminate blocks.
  function automatic logic code_is_valid(input logic [6:0] code);
    return (code == CC_IDLE) || (code == CC_ERR);
  endfunction

  // Anything that is not an idle code is reported as an XGMII error character.
  function automatic logic [7:0] code_to_char(input logic [6:0] code);
    return (code == CC_IDLE) ? XG_IDLE : XG_ERROR;
  endfunction

endpackage

// File: rtl/pcs_rx_block_decode.sv
// ---------------------------------------------------------------------------
// pcs_rx_block_decode
//
// Purely combinational classification and raw decode of one 66-bit block.
// No knowledge of frame context: the caller decides whether the block is
// legal in the current state and substitutes /E/ when it is not.
//
// Ports:
//   header    in   2  sync header (01 data, 10 control, others invalid)
//   data      in  64  descrambled payload, block type in [7:0]
//   blk_class out  3  block class, values from blk_class_e
//   rxd       out 64  decoded XGMII lanes, lane n in [8n+7:8n]
//   rxc       out  8  per-lane control flags
// ---------------------------------------------------------------------------
module pcs_rx_block_decode
  import pcs_rx_decoder_pkg::*;
(
  input  logic [1:0]  header,
  input  logic [63:0] data,
  output logic [2:0]  blk_class,
  output logic [63:0] rxd,
  output logic [7:0]  rxc
);

  logic [63:0] payload;
  logic [7:0]  code_ok;
  logic [63:0] code_rxd;
  logic [63:0] term_rxd;
  logic        is_term;
  logic        term_ok;
  int          term_k;

  // Payload bytes shifted down by one so that lane j of an S0 or Tk block is
  // simply byte j of this vector.
  assign payload = {8'h00, data[63:8]};

  // Map the terminate block type onto the lane that carries /T/.
  always_comb begin
    is_term = 1'b0;
    term_k  = 0;
    case (data[7:0])
      BT_T0: begin is_term = 1'b1; term_k = 0; end
      BT_T1: begin is_term = 1'b1; term_k = 1; end
      BT_T2: begin is_term = 1'b1; term_k = 2; end
      BT_T3: begin is_term = 1'b1; term_k = 3; end
      BT_T4: begin is_term = 1'b1; term_k = 4; end
      BT_T5: begin is_term = 1'b1; term_k = 5; end
      BT_T6: begin is_term = 1'b1; term_k = 6; end
      BT_T7: begin is_term = 1'b1; term_k = 7; end
      default: begin is_term = 1'b0; term_k = 0; end
    endcase
  end

  // In every control block format the 7-bit code for lane j sits at bit 8+7j,
  // so one set of code decoders serves C, S4 and all Tk layouts. Terminate
  // lanes before /T/ take data bytes, lanes after it take codes.
  always_comb begin
    code_ok  = '0;
    code_rxd = '0;
    term_rxd = '0;
    term_ok  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      code_ok[j]         = code_is_valid(data[8+7*j +: 7]);
      code_rxd[8*j +: 8] = code_to_char(data[8+7*j +: 7]);
      if (j < term_k) begin
        term_rxd[8*j +: 8] = payload[8*j +: 8];
      end else if (j == term_k) begin
        term_rxd[8*j +: 8] = XG_TERM;
      end else begin
        term_rxd[8*j +: 8] = code_rxd[8*j +: 8];
        if (!code_ok[j]) begin
          term_ok = 1'b0;
        end
      end
    end
  end

  // Classify the block and produce its raw lanes; anything unrecognised or
  // carrying an illegal code falls through to the /E/ default.
  always_comb begin
    blk_class = BLK_E;
    rxd       = XG_ERR_BLOCK;
    rxc       = XC_ALL_CTRL;
    if (header == SH_DATA) begin
      blk_class = BLK_D;
      rxd       = data;
      rxc       = 8'h00;
    end else if (header == SH_CTRL) begin
      case (data[7:0])
        BT_C: begin
          if (&code_ok) begin
            blk_class = BLK_C;
            rxd       = code_rxd;
            rxc       = XC_ALL_CTRL;
          end
        end
        BT_S0: begin
          blk_class = BLK_S;
          rxd       = {data[63:8], XG_START};
          rxc       = 8'h01;
        end
        BT_S4: begin
          blk_class = BLK_S;
          rxd       = {data[63:40], XG_START, code_rxd[31:0]};
          rxc       = 8'h1F;
        end
        default: begin
          if (is_term && term_ok) begin
            blk_class = BLK_T;
            rxd       = term_rxd;
            rxc       = XC_ALL_CTRL << term_k;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pcs_rx_decoder.sv
// ---------------------------------------------------------------------------
// pcs_rx_decoder
//
// Receive 64b/66b decoder: turns one valid 66-bit block per cycle into one
// registered XGMII beat, enforcing the receive state machine. Blocks that are
// illegal in the current state are replaced by /E/ and counted.
//
// Ports:
//   i_clk         in   1  PCS receive clock
//   i_reset_n     in   1  asynchronous active-low reset
//   i_header      in   2  sync header
//   i_data        in  64  descrambled payload, block type in [7:0]
//   i_valid       in   1  block present this cycle
//   i_block_lock  in   1  block lock status
//   i_err_clear   in   1  synchronous clear of o_err_count
//   xgmii_rxd     out 64  decoded lanes
//   xgmii_rxc     out  8  per-lane control flags
//   o_valid       out  1  outputs updated this cycle
//   o_err_count   out  W  saturating count of /E/ blocks emitted
// ---------------------------------------------------------------------------
module pcs_rx_decoder
  import pcs_rx_decoder_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [1:0]               i_header,
  input  logic [63:0]              i_data,
  input  logic                     i_valid,
  input  logic                     i_block_lock,
  input  logic                     i_err_clear,
  output logic [63:0]              xgmii_rxd,
  output logic [7:0]               xgmii_rxc,
  output logic                     o_valid,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  logic [2:0]  blk_class;
  logic [63:0] dec_rxd;
  logic [7:0]  dec_rxc;
  rx_state_e   state;
  rx_state_e   next_state;
  logic        emit_error;
  logic        err_event;

  pcs_rx_block_decode u_block_decode (
    .header    (i_header),
    .data      (i_data),
    .blk_class (blk_class),
    .rxd       (dec_rxd),
    .rxc       (dec_rxc)
  );

  // Legality of the incoming block given where we are in the frame. INIT and
  // C behave identically; E accepts any recognised block so the link can
  // resynchronise without waiting for a fresh start.
  always_comb begin
    next_state = state;
    emit_error = 1'b0;
    case (state)
      ST_INIT, ST_C: begin
        case (blk_class)
          BLK_C:   next_state = ST_C;
          BLK_S:   next_state = ST_D;
          default: begin next_state = ST_E; emit_error = 1'b1; end
        endcase
      end
      ST_D: begin
        case (blk_class)
          BLK_D:   next_state = ST_D;
          BLK_T:   next_state = ST_C;
          default: begin next_state = ST_E; emit_error = 1'b1; end
        endcase
      end
      ST_E: begin
        case (blk_class)
          BLK_C:   next_state = ST_C;
          BLK_S:   next_state = ST_D;
          BLK_D:   next_state = ST_D;
          BLK_T:   next_state = ST_C;
          default: begin next_state = ST_E; emit_error = 1'b1; end
        endcase
      end
      default: begin next_state = ST_E; emit_error = 1'b1; end
    endcase
  end

  // Only a block that is actually presented while locked can be counted;
  // lock loss produces a local-fault beat, not an error.
  assign err_event = i_valid && i_block_lock && emit_error;

  // State and output register. Pause cycles hold everything and only drop
  // o_valid; losing lock forces INIT so the next frame needs a start block.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_INIT;
      xgmii_rxd <= XG_IDLE_BLOCK;
      xgmii_rxc <= XC_ALL_CTRL;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        if (!i_block_lock) begin
          state     <= ST_INIT;
          xgmii_rxd <= XG_LBLOCK;
          xgmii_rxc <= XC_LBLOCK;
        end else begin
          state <= next_state;
          if (emit_error) begin
            xgmii_rxd <= XG_ERR_BLOCK;
            xgmii_rxc <= XC_ALL_CTRL;
          end else begin
            xgmii_rxd <= dec_rxd;
            xgmii_rxc <= dec_rxc;
          end
        end
      end
    end
  end

  // Saturating error counter; a clear wins over a simultaneous increment.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err_count <= '0;
    end else if (i_err_clear) begin
      o_err_count <= '0;
    end else if (err_event && (o_err_count != CNT_MAX)) begin
      o_err_count <= o_err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pcs_rx_decoder.sv
// ---------------------------------------------------------------------------
// tb_pcs_rx_decoder
//
// Builds 66-bit blocks from known XGMII beats, so the expected decode of a
// legal block is the beat it was built from. A frame-level model decides
// whether each block is legal in context and tracks the error counter.
// ---------------------------------------------------------------------------
module tb_pcs_rx_decoder;

  localparam int K_C = 0;
  localparam int K_S = 1;
  localparam int K_T = 2;
  localparam int K_D = 3;
  localparam int K_E = 4;

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] data;
    logic [63:0] xd;
    logic [7:0]  xc;
    int          kind;
  } blk_t;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [1:0]  i_header = 2'b10;
  logic [63:0] i_data = 64'h1E;
  logic        i_valid = 1'b0;
  logic        i_block_lock = 1'b1;
  logic        i_err_clear = 1'b0;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        o_valid;
  logic [3:0]  o_err_count;

  int total = 0;
  int bad = 0;

  // Frame-level model: 0 = between frames, 1 = inside a frame, 2 = error.
  int          m_state;
  int          m_count;
  logic [63:0] m_rxd;
  logic [7:0]  m_rxc;
  logic        m_valid;

  pcs_rx_decoder #(.ERR_CNT_WIDTH(4)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_header     (i_header),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_block_lock (i_block_lock),
    .i_err_clear  (i_err_clear),
    .xgmii_rxd    (xgmii_rxd),
    .xgmii_rxc    (xgmii_rxc),
    .o_valid      (o_valid),
    .o_err_count  (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic blk_t build_idle(input logic [7:0] err_lanes);
    blk_t b;
    b.hdr = 2'b10; b.data = 64'h1E; b.xc = 8'hFF; b.kind = K_C; b.xd = '0;
    for (int j = 0; j < 8; j++) begin
      b.xd[8*j +: 8]    = err_lanes[j] ? 8'hFE : 8'h07;
      b.data[8+7*j +: 7] = err_lanes[j] ? 7'h1E : 7'h00;
    end
    return b;
  endfunction

  function automatic blk_t build_s0(input logic [55:0] pl);
    blk_t b;
    b.hdr = 2'b10; b.data = {pl, 8'h78}; b.xd = {pl, 8'hFB}; b.xc = 8'h01; b.kind = K_S;
    return b;
  endfunction

  function automatic blk_t build_s4(input logic [23:0] pl);
    blk_t b;
    b.hdr = 2'b10; b.data = {pl, 32'h0, 8'h33};
    b.xd = {pl, 8'hFB, 32'h07070707}; b.xc = 8'h1F; b.kind = K_S;
    return b;
  endfunction

  function automatic blk_t build_data(input logic [63:0] d);
    blk_t b;
    b.hdr = 2'b01; b.data = d; b.xd = d; b.xc = 8'h00; b.kind = K_D;
    return b;
  endfunction

  function automatic blk_t build_term(input int k, input logic [63:0] r);
    blk_t b;
    logic [7:0] tt [8];
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    b.hdr = 2'b10; b.data = '0; b.xd = '0; b.xc = '0; b.kind = K_T;
    b.data[7:0] = tt[k];
    for (int j = 0; j < 8; j++) begin
      b.xc[j] = (j >= k);
      if (j < k) begin
        b.xd[8*j +: 8]     = r[8*j +: 8];
        b.data[8*j+8 +: 8] = r[8*j +: 8];
      end else if (j == k) begin
        b.xd[8*j +: 8] = 8'hFD;
      end else begin
        b.xd[8*j +: 8] = 8'h07;
      end
    end
    return b;
  endfunction

  function automatic blk_t build_bad(input int variant, input logic [63:0] r);
    blk_t b;
    logic [7:0] ut [4];
    ut = '{8'h4B, 8'h2D, 8'h66, 8'h55};
    case (variant)
      0: begin b.hdr = 2'b00; b.data = r; end
      1: begin b.hdr = 2'b11; b.data = r; end
      2: begin b.hdr = 2'b10; b.data = {r[63:8], ut[r[1:0]]}; end
      3: begin
        b = build_idle(8'h00);
        b.data[8+7*int'(r[2:0]) +: 7] = 7'h2D;
      end
      default: begin
        b = build_term(int'(r[2:0]) % 7, r);
        b.data[63:57] = 7'h55;
      end
    endcase
    b.xd = {8{8'hFE}}; b.xc = 8'hFF; b.kind = K_E;
    return b;
  endfunction

  task automatic modelReset();
    m_state = 0; m_count = 0; m_rxd = {8{8'h07}}; m_rxc = 8'hFF; m_valid = 1'b0;
  endtask

  // Drive one block, advance the model by the frame rules, and wait until
  // just after the capturing edge.
  task automatic applyStimulus(input blk_t b, input logic valid, input logic lock,
                               input logic clr);
    logic legal;
    logic err;
    i_header = b.hdr; i_data = b.data; i_valid = valid;
    i_block_lock = lock; i_err_clear = clr;
    err = 1'b0;
    m_valid = valid;
    if (valid) begin
      if (!lock) begin
        m_state = 0; m_rxd = 64'h0100009C_0100009C; m_rxc = 8'h11;
      end else begin
        case (m_state)
          0:       legal = (b.kind == K_C) || (b.kind == K_S);
          1:       legal = (b.kind == K_D) || (b.kind == K_T);
          default: legal = (b.kind != K_E);
        endcase
        if (legal) begin
          m_rxd = b.xd; m_rxc = b.xc;
          m_state = ((b.kind == K_S) || (b.kind == K_D)) ? 1 : 0;
        end else begin
          m_rxd = {8{8'hFE}}; m_rxc = 8'hFF; m_state = 2; err = 1'b1;
        end
      end
    end
    if (clr) m_count = 0;
    else if (err && m_count < 15) m_count = m_count + 1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (xgmii_rxd === m_rxd) else begin
      bad++; $error("[TB] FAIL %s rxd got=%h exp=%h", tag, xgmii_rxd, m_rxd);
    end
    total++;
    assert (xgmii_rxc === m_rxc) else begin
      bad++; $error("[TB] FAIL %s rxc got=%h exp=%h", tag, xgmii_rxc, m_rxc);
    end
    total++;
    assert (o_valid === m_valid) else begin
      bad++; $error("[TB] FAIL %s valid got=%b exp=%b", tag, o_valid, m_valid);
    end
    total++;
    assert (o_err_count === 4'(m_count)) else begin
      bad++; $error("[TB] FAIL %s count got=%0d exp=%0d", tag, o_err_count, m_count);
    end
  endtask

  initial begin
    blk_t b;
    int   sel;
    modelReset();
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset");
    i_reset_n = 1'b1;

    $display("[TB] idle stream");
    repeat (3) begin
      applyStimulus(build_idle(8'h00), 1'b1, 1'b1, 1'b0);
      checkOutput("idle");
    end

    $display("[TB] S0 frame ending in T3");
    applyStimulus(build_s0(56'hD5_55_55_55_55_55_55), 1'b1, 1'b1, 1'b0);
    checkOutput("s0");
    repeat (3) begin
      applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
      checkOutput("s0_data");
    end
    applyStimulus(build_term(3, {$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("t3");
    applyStimulus(build_idle(8'h00), 1'b1, 1'b1, 1'b0);
    checkOutput("t3_idle");

    $display("[TB] S4 frame with a pause cycle");
    applyStimulus(build_s4(24'(($urandom))), 1'b1, 1'b1, 1'b0);
    checkOutput("s4");
    applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("s4_data");
    applyStimulus(build_bad(0, {$urandom, $urandom}), 1'b0, 1'b1, 1'b0);
    checkOutput("pause_hold");
    applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("s4_data2");
    applyStimulus(build_term(5, {$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("t5");

    $display("[TB] sequence errors");
    applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("d_after_idle");
    applyStimulus(build_idle(8'h00), 1'b1, 1'b1, 1'b0);
    checkOutput("recover1");
    applyStimulus(build_s0(56'(({$urandom, $urandom}))), 1'b1, 1'b1, 1'b0);
    checkOutput("s0_b");
    applyStimulus(build_bad(1, {$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("hdr11_mid");
    applyStimulus(build_idle(8'h00), 1'b1, 1'b1, 1'b0);
    checkOutput("recover2");

    $display("[TB] lock loss mid-frame");
    applyStimulus(build_s0(56'(({$urandom, $urandom}))), 1'b1, 1'b1, 1'b0);
    checkOutput("s0_c");
    applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b0, 1'b0);
    checkOutput("lock_lost");
    applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("relock_d");
    applyStimulus(build_s0(56'(({$urandom, $urandom}))), 1'b1, 1'b1, 1'b0);
    checkOutput("relock_s");

    $display("[TB] reset mid-frame");
    applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("pre_reset");
    i_reset_n = 1'b0;
    #2;
    modelReset();
    checkOutput("async_reset");
    i_reset_n = 1'b1;
    applyStimulus(build_data({$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
    checkOutput("post_reset_d");

    $display("[TB] randomized blocks");
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 9: b = build_idle(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        1:    b = build_s0(56'(({$urandom, $urandom})));
        2:    b = build_s4(24'($urandom));
        3, 4, 5: b = build_data({$urandom, $urandom});
        6, 7: b = build_term($urandom_range(0, 7), {$urandom, $urandom});
        default: b = build_bad($urandom_range(0, 4), {$urandom, $urandom});
      endcase
      applyStimulus(b, $urandom_range(0, 9) != 0, $urandom_range(0, 29) != 0,
                    $urandom_range(0, 39) == 0);
      checkOutput("rand");
    end

    $display("[TB] counter saturation");
    applyStimulus(build_idle(8'h00), 1'b1, 1'b1, 1'b1);
    checkOutput("sat_clear");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(build_bad(0, {$urandom, $urandom}), 1'b1, 1'b1, 1'b0);
      checkOutput("sat");
    end
    applyStimulus(build_bad(1, {$urandom, $urandom}), 1'b1, 1'b1, 1'b1);
    checkOutput("clear_wins");
    applyStimulus(build_idle(8'h00), 1'b1, 1'b1, 1'b0);
    checkOutput("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
